// File: rtl/game_pkg.sv
// Shared types and helpers for the minesweeper game timer.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUNNING,
    PAUSED,
    DONE
  } state_t;

  localparam int BCD_W = 4;

  function automatic int presc_w(input int div);
    return (div > 2) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/game_timer_ctrl_bcd_digit.sv
// One BCD digit of the timer cascade; wraps 9 -> 0 on a carried increment.
module bcd_digit
  import game_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             carry_in,
  output logic [BCD_W-1:0] digit,
  output logic             is_nine
);

  assign is_nine = (digit == BCD_W'(9));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      digit <= '0;
    end else if (en && carry_in) begin
      digit <= is_nine ? '0 : digit + 1'b1;
    end
  end

endmodule

// File: rtl/game_timer_ctrl.sv
// Game timer controller: prescaler, command FSM and BCD digit cascade.
module game_timer_ctrl
  import game_pkg::*;
#(
  parameter int CLK_HZ  = 65_000_000,
  parameter int TICK_HZ = 1,
  parameter int DIGITS  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                pause,
  input  logic                stop,
  input  logic                clear,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                tick,
  output logic                running,
  output logic                saturated
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = presc_w(DIV);
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

  state_t            state, state_nx;
  logic [PW-1:0]     presc, presc_nx;
  logic              en;
  logic              hi_nine;
  logic              will_sat;
  logic [DIGITS-1:0] nine;
  logic [DIGITS-1:0] carry;

  assign saturated = &nine;

  // Next increment lands on all-9s: units at 8, every higher digit at 9.
  always_comb begin
    hi_nine = 1'b1;
    for (int i = 1; i < DIGITS; i++) begin
      hi_nine = hi_nine & nine[i];
    end
  end

  assign will_sat = hi_nine && (bcd_out[BCD_W-1:0] == BCD_W'(8));

  always_comb begin
    state_nx = state;
    presc_nx = presc;
    en       = 1'b0;
    if (clear) begin
      state_nx = IDLE;
      presc_nx = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state_nx = RUNNING;
            presc_nx = '0;
          end
        end
        RUNNING: begin
          if (stop) begin
            state_nx = DONE;
          end else if (pause) begin
            state_nx = PAUSED;
          end else if (presc == PMAX) begin
            presc_nx = '0;
            en       = 1'b1;
            if (will_sat) state_nx = DONE;
          end else begin
            presc_nx = presc + 1'b1;
          end
        end
        PAUSED: begin
          if (stop) state_nx = DONE;
          else if (start) state_nx = RUNNING;
        end
        DONE: begin
          state_nx = DONE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      presc   <= '0;
      tick    <= 1'b0;
      running <= 1'b0;
    end else begin
      state   <= state_nx;
      presc   <= presc_nx;
      tick    <= en;
      running <= (state_nx == RUNNING);
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    if (i == 0) begin : g_c0
      assign carry[i] = 1'b1;
    end else begin : g_cn
      assign carry[i] = carry[i-1] & nine[i-1];
    end

    bcd_digit u_dig (
      .clk      (clk),
      .rst      (rst),
      .clr      (clear),
      .en       (en),
      .carry_in (carry[i]),
      .digit    (bcd_out[4*i +: 4]),
      .is_nine  (nine[i])
    );
  end

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Scoreboard bench: 3-digit and 2-digit timers driven by shared commands.
module tb_game_timer_ctrl;

  localparam int DIV = 10;
  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_PAU  = 2;
  localparam int S_DONE = 3;

  typedef struct {
    logic        tick;
    logic [11:0] bcd;
    logic        run;
    logic        sat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, start, pause, stop, clear;
  logic [11:0] bcd3;
  logic [7:0]  bcd2;
  logic        tick3, run3, sat3;
  logic        tick2, run2, sat2;

  int vectors = 0;
  int miscompares = 0;
  int ncyc = 0;

  exp_t q3[$];
  exp_t q2[$];

  int m_st[2];
  int m_pre[2];
  int m_cnt[2];
  int m_tick[2];

  always #5 clk = ~clk;

  game_timer_ctrl #(.CLK_HZ(10), .TICK_HZ(1), .DIGITS(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start), .pause(pause),
    .stop(stop), .clear(clear), .bcd_out(bcd3), .tick(tick3),
    .running(run3), .saturated(sat3)
  );

  game_timer_ctrl #(.CLK_HZ(10), .TICK_HZ(1), .DIGITS(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .pause(pause),
    .stop(stop), .clear(clear), .bcd_out(bcd2), .tick(tick2),
    .running(run2), .saturated(sat2)
  );

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 3; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Reference: elapsed seconds as a plain integer, phase of current second.
  function automatic void model_step(input int m, input logic r,
                                     input logic c, input logic s,
                                     input logic p, input logic t);
    int maxc;
    maxc = (m == 0) ? 999 : 99;
    m_tick[m] = 0;
    if (r || c) begin
      m_st[m] = S_IDLE;
      m_pre[m] = 0;
      m_cnt[m] = 0;
    end else if (m_st[m] == S_IDLE) begin
      if (s) begin
        m_st[m] = S_RUN;
        m_pre[m] = 0;
      end
    end else if (m_st[m] == S_RUN) begin
      if (t) m_st[m] = S_DONE;
      else if (p) m_st[m] = S_PAU;
      else if (m_pre[m] == DIV - 1) begin
        m_pre[m] = 0;
        m_cnt[m] = m_cnt[m] + 1;
        m_tick[m] = 1;
        if (m_cnt[m] == maxc) m_st[m] = S_DONE;
      end else begin
        m_pre[m] = m_pre[m] + 1;
      end
    end else if (m_st[m] == S_PAU) begin
      if (t) m_st[m] = S_DONE;
      else if (s) m_st[m] = S_RUN;
    end
  endfunction

  function automatic exp_t model_out(input int m);
    exp_t e;
    e.tick = (m_tick[m] != 0);
    e.bcd  = to_bcd(m_cnt[m]);
    e.run  = (m_st[m] == S_RUN);
    e.sat  = (m_cnt[m] == ((m == 0) ? 999 : 99));
    return e;
  endfunction

  task automatic cyc(input logic r, input logic c, input logic s,
                     input logic p, input logic t);
    rst = r;
    clear = c;
    start = s;
    pause = p;
    stop = t;
    model_step(0, r, c, s, p, t);
    model_step(1, r, c, s, p, t);
    @(posedge clk);
    q3.push_back(model_out(0));
    q2.push_back(model_out(1));
    ncyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  // Monitor: every clock edge presents a fresh output set to check.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q3.size() > 0) begin
        e = q3.pop_front();
        vectors++;
        if ({tick3, bcd3, run3, sat3} !== {e.tick, e.bcd, e.run, e.sat}) begin
          miscompares++;
          $display("FAIL d3 cyc=%0d got tick=%b bcd=%h run=%b sat=%b exp tick=%b bcd=%h run=%b sat=%b",
                   ncyc, tick3, bcd3, run3, sat3, e.tick, e.bcd, e.run, e.sat);
        end
      end
      if (q2.size() > 0) begin
        e = q2.pop_front();
        vectors++;
        if ({tick2, bcd2, run2, sat2} !== {e.tick, e.bcd[7:0], e.run, e.sat}) begin
          miscompares++;
          $display("FAIL d2 cyc=%0d got tick=%b bcd=%h run=%b sat=%b exp tick=%b bcd=%h run=%b sat=%b",
                   ncyc, tick2, bcd2, run2, sat2, e.tick, e.bcd[7:0], e.run, e.sat);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    pause = 1'b0;
    stop = 1'b0;
    clear = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_st[i] = S_IDLE;
      m_pre[i] = 0;
      m_cnt[i] = 0;
      m_tick[i] = 0;
    end
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    // first tick DIV cycles after start; then carries at 10 and 100
    cyc(0, 0, 1, 0, 0);
    idle(1060);
    cyc(0, 1, 0, 0, 0);
    // pause after 4 running cycles, hold, resume
    cyc(0, 0, 1, 0, 0);
    idle(4);
    cyc(0, 0, 0, 1, 0);
    idle(50);
    cyc(0, 0, 1, 0, 0);
    idle(8);
    cyc(0, 1, 0, 0, 0);
    // 2-digit saturation, then ignored start and extra intervals
    cyc(0, 0, 1, 0, 0);
    idle(1000);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0);
    idle(300);
    cyc(0, 1, 0, 0, 0);
    // pause coincides with enable; clear+start together
    cyc(0, 0, 1, 0, 0);
    idle(9);
    cyc(0, 0, 0, 1, 0);
    idle(15);
    cyc(0, 1, 1, 0, 0);
    idle(3);
    // stop at 42, clear, restart, reset mid-run
    cyc(0, 0, 1, 0, 0);
    idle(424);
    cyc(0, 0, 0, 0, 1);
    idle(20);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    idle(33);
    cyc(1, 0, 0, 0, 0);
    idle(5);
    // random command traffic
    for (int i = 0; i < 20000; i++) begin
      cyc($urandom_range(0, 1999) == 0,
          $urandom_range(0, 399) == 0,
          $urandom_range(0, 29) == 0,
          $urandom_range(0, 149) == 0,
          $urandom_range(0, 499) == 0);
    end
    // 3-digit saturation
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    idle(10010);
    cyc(0, 0, 1, 0, 0);
    idle(30);
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (q3.size() + q2.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending exp 0", q3.size() + q2.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
